cpu_core: RTL

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_pkg.sv | 63 ++++++
 rtl/cpu_alu.sv | 13 +
 rtl/cpu_core.sv | 95 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode map, instruction field layout and decode for the tiny accumulator core.
package cpu_pkg;

   // Instruction word: {opcode[OPC_W-1:0], imm[DATA_W-1:0]}
   localparam int OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_ADDA  = 4'b0000;
   localparam logic [OPC_W-1:0] OP_MOVAB = 4'b0001;
   localparam logic [OPC_W-1:0] OP_INA   = 4'b0010;
   localparam logic [OPC_W-1:0] OP_MOVAI = 4'b0011;
   localparam logic [OPC_W-1:0] OP_MOVBA = 4'b0100;
   localparam logic [OPC_W-1:0] OP_ADDB  = 4'b0101;
   localparam logic [OPC_W-1:0] OP_INB   = 4'b0110;
   localparam logic [OPC_W-1:0] OP_MOVBI = 4'b0111;
   localparam logic [OPC_W-1:0] OP_HALT  = 4'b1000;
   localparam logic [OPC_W-1:0] OP_OUTB  = 4'b1001;
   localparam logic [OPC_W-1:0] OP_OUTI  = 4'b1011;
   localparam logic [OPC_W-1:0] OP_JNC   = 4'b1110;
   localparam logic [OPC_W-1:0] OP_JMP   = 4'b1111;

   typedef enum logic [1:0] {
      SRC_ZERO,
      SRC_A,
      SRC_B,
      SRC_IN
   } src_t;

   typedef struct packed {
      src_t src;
      logic useImm;
      logic wrA;
      logic wrB;
      logic wrOut;
      logic jmp;
      logic jnc;
      logic halt;
   } ctrl_t;

   // Unlisted opcodes fall through as NOP: zero + zero, no writes.
   function automatic ctrl_t decode(input logic [OPC_W-1:0] opc);
      ctrl_t c;
      c = '0;
      c.src = SRC_ZERO;
      unique case (opc)
         OP_ADDA:  begin c.src = SRC_A;  c.useImm = 1'b1; c.wrA = 1'b1; end
         OP_MOVAB: begin c.src = SRC_B;  c.wrA = 1'b1; end
         OP_INA:   begin c.src = SRC_IN; c.wrA = 1'b1; end
         OP_MOVAI: begin c.useImm = 1'b1; c.wrA = 1'b1; end
         OP_MOVBA: begin c.src = SRC_A;  c.wrB = 1'b1; end
         OP_ADDB:  begin c.src = SRC_B;  c.useImm = 1'b1; c.wrB = 1'b1; end
         OP_INB:   begin c.src = SRC_IN; c.wrB = 1'b1; end
         OP_MOVBI: begin c.useImm = 1'b1; c.wrB = 1'b1; end
         OP_OUTB:  begin c.src = SRC_B;  c.wrOut = 1'b1; end
         OP_OUTI:  begin c.useImm = 1'b1; c.wrOut = 1'b1; end
         OP_JNC:   c.jnc = 1'b1;
         OP_JMP:   c.jmp = 1'b1;
         OP_HALT:  c.halt = 1'b1;
         default:  ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Single adder shared by every data-moving instruction.
module cpu_alu #(
   parameter int DATA_W = 4
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] sum,
   output logic              cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/cpu_core.sv
// Single-cycle two-register core: fetch from external ROM, decode,
// add, write back and update pc all on one rising edge.
module cpu_core
   import cpu_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    run,
   input  logic [DATA_W-1:0]       in_port,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W+OPC_W-1:0] rom_data,
   output logic [DATA_W-1:0]       out_port,
   output logic                    out_valid,
   output logic                    carry,
   output logic                    halted
);

   logic [DATA_W-1:0] regA;
   logic [DATA_W-1:0] regB;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] nextPc;
   logic [OPC_W-1:0]  opc;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] srcVal;
   logic [DATA_W-1:0] addend;
   logic [DATA_W-1:0] sum;
   logic              sumCarry;
   logic              exec;
   ctrl_t             ctl;

   assign opc      = rom_data[DATA_W+OPC_W-1 -: OPC_W];
   assign imm      = rom_data[DATA_W-1:0];
   assign ctl      = decode(opc);
   assign rom_addr = pc;
   assign exec     = run & ~halted;
   assign addend   = ctl.useImm ? imm : '0;

   always_comb begin
      srcVal = '0;
      unique case (ctl.src)
         SRC_A:    srcVal = regA;
         SRC_B:    srcVal = regB;
         SRC_IN:   srcVal = in_port;
         default:  srcVal = '0;
      endcase
   end

   // JNC looks at the carry left by the previous instruction.
   always_comb begin
      nextPc = pc + 1'b1;
      if (ctl.jmp || (ctl.jnc && !carry))
         nextPc = imm[ADDR_W-1:0];
   end

   cpu_alu #(.DATA_W(DATA_W)) alu (
      .a    (srcVal),
      .b    (addend),
      .sum  (sum),
      .cout (sumCarry)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         regA      <= '0;
         regB      <= '0;
         pc        <= '0;
         out_port  <= '0;
         out_valid <= 1'b0;
         carry     <= 1'b0;
         halted    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (exec) begin
            carry <= sumCarry;
            if (ctl.halt) begin
               halted <= 1'b1;
            end else begin
               pc <= nextPc;
               if (ctl.wrA)
                  regA <= sum;
               if (ctl.wrB)
                  regB <= sum;
               if (ctl.wrOut) begin
                  out_port  <= sum;
                  out_valid <= 1'b1;
               end
            end
         end
      end
   end

endmodule
